if_axi_fetch_ctrl: RTL
======================

Name: if_axi_fetch_ctrl

Overview:
Instruction-fetch controller sitting between the PC register / IF-ID pipeline bar and the instruction-memory AXI4 read master port. Issues one single-beat AXI read per PC, holds the pipeline with fetch_stall until the instruction returns, and delivers a registered instruction to IF/ID. Handles branch redirects that arrive mid-transaction by completing the AXI handshake and discarding the stale beat. Flags bus errors and timeouts by delivering a NOP.

Parameters:
ADDR_W, 32, AXI address / PC width
DATA_W, 32, AXI read data / instruction width
ID_W, 4, ARID width
FETCH_ID, 0, constant driven on ARID
TIMEOUT, 255, max DATA-state cycles without RVALID before error; 0 disables the timeout

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
pc_req  input  ADDR_W  current PC from PC register
pc_redirect  input  1  branch/jump taken in EX this cycle (1-cycle pulse)
dm_busy  input  1  data-memory AXI stall; pipeline frozen
ARID  output  ID_W  = FETCH_ID
ARADDR  output  ADDR_W  registered fetch address
ARLEN  output  8  constant 0
ARSIZE  output  3  constant 3'b010
ARBURST  output  2  constant 2'b01 (INCR)
ARVALID  output  1  address valid
ARREADY  input  1  address accepted
RDATA  input  DATA_W  read data
RRESP  input  2  read response
RLAST  input  1  last beat (expected 1)
RVALID  input  1  data valid
RREADY  output  1  data ready
inst_out  output  DATA_W  fetched instruction to IF/ID
inst_valid  output  1  inst_out valid this cycle
fetch_stall  output  1  hold PC and IF/ID (PC-side AXI stall)
fetch_err  output  1  1-cycle pulse: RRESP != OKAY or timeout

Behaviour:
- Reset values: ARVALID=0, RREADY=0, ARADDR=0, inst_out=0, inst_valid=0, fetch_stall=1, fetch_err=0, discard=0, timeout counter=0, state=IDLE. Reset asserted in any state returns to IDLE at the next edge; the outstanding AXI transaction is abandoned (interconnect shares rst).
- States: IDLE, ADDR, DATA, DONE.
- IDLE: unconditionally -> ADDR next cycle; ARADDR <= pc_req on that edge.
- ADDR: ARVALID=1, ARADDR stable. ARVALID never drops before ARREADY. ARVALID&ARREADY -> DATA; counter cleared.
- DATA: RREADY=1. On RVALID: inst_out <= (RRESP==2'b00) ? RDATA : 32'h00000013; fetch_err pulses the next cycle if RRESP!=OKAY. If discard=1, the beat is dropped, discard cleared, ARADDR <= pc_req, -> ADDR; otherwise -> DONE. Without RVALID the counter increments; when the counter reaches TIMEOUT (TIMEOUT!=0): inst_out <= NOP, fetch_err pulse, -> DONE (or -> ADDR if discard). RLAST is not checked.
- DONE: fetch_stall=0, inst_valid=1 (0 when pc_redirect=1 this cycle). If dm_busy=1 and pc_redirect=0, stay in DONE and hold inst_out. Otherwise ARADDR <= pc_req, -> ADDR.
- fetch_stall=1 in IDLE, ADDR, DATA; 0 only in DONE.
- Redirect: pc_redirect in ADDR or DATA sets discard=1; the transaction completes per AXI rules. pc_redirect in the cycle the accepted beat arrives in DATA is treated as discard. In DONE, a redirect goes to ADDR with pc_req (already updated) and suppresses inst_valid.
- Latency: minimum 3 cycles per instruction (ADDR, DATA, DONE) with ARREADY and RVALID both zero-wait.
- Counter width is clog2(TIMEOUT+1); it saturates and does not wrap.

Test Plan:
- Zero-wait fetch: reset, pc_req=0x0, ARREADY=1, RVALID=1 with RDATA=0x00500093 the cycle after the AR handshake -> ARADDR=0x0, inst_out=0x00500093, inst_valid=1 and fetch_stall=0 for exactly one cycle, next ARADDR=pc_req (0x4).
- Wait states: ARREADY delayed 3 cycles, RVALID delayed 5 -> ARVALID held high with ARADDR stable for 3 cycles, fetch_stall=1 throughout, single inst_valid pulse.
- Redirect mid-DATA: pc_redirect in DATA, pc_req=0x100, RDATA=0xDEADBEEF -> beat dropped, no inst_valid, next ARADDR=0x100, next inst_out comes from 0x100.
- dm_busy hold: dm_busy=1 for 4 cycles while in DONE -> inst_out stable, no new ARVALID until dm_busy=0.
- Error/timeout: RRESP=2'b10 -> inst_out=0x00000013, fetch_err one-cycle pulse; with TIMEOUT=4 and no RVALID -> NOP plus fetch_err after 4 DATA cycles.
- Reset mid-transaction: rst in DATA -> ARVALID=0, RREADY=0, fetch_stall=1 next cycle, fetch restarts from IDLE.

Source files
------------

// File: rtl/if_axi_fetch_ctrl.sv
// Instruction-fetch controller: one single-beat AXI4 read per PC and a registered
// instruction to IF/ID. A redirect during a fetch drains the stale beat before refetching.
module if_axi_fetch_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ID_W     = 4,
    parameter int FETCH_ID = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_req,
    input  logic              pc_redirect,
    input  logic              dm_busy,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [DATA_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              fetch_stall,
    output logic              fetch_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_araddr;
    logic [DATA_W-1:0] r_inst;
    logic              r_err;
    logic              r_discard;
    logic [CNT_W-1:0]  r_cnt;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_cnt_max;
    logic              w_timeout;
    logic              w_drop;
    logic              w_unused;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_cnt_max = (r_cnt == {CNT_W{1'b1}});
    // Fires on the DATA cycle whose increment would bring the counter to TIMEOUT.
    assign w_timeout = (TIMEOUT != 0) && !RVALID && (w_cnt_inc == CNT_W'(TIMEOUT));
    // A redirect coinciding with the returning beat still makes that beat stale.
    assign w_drop    = r_discard || pc_redirect;
    assign w_unused  = RLAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_araddr  <= '0;
            r_inst    <= '0;
            r_err     <= 1'b0;
            r_discard <= 1'b0;
            r_cnt     <= '0;
        end else begin
            // NOTE: default pulse value first; a later non-blocking assignment in this block wins.
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_araddr <= pc_req;
                    r_state  <= S_ADDR;
                end
                S_ADDR: begin
                    if (pc_redirect) r_discard <= 1'b1;
                    if (ARREADY) begin
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (RVALID || w_timeout) begin
                        r_inst    <= (RVALID && RRESP == 2'b00) ? RDATA : NOP;
                        r_err     <= !RVALID || (RRESP != 2'b00);
                        r_discard <= 1'b0;
                        if (w_drop) begin
                            r_araddr <= pc_req;
                            r_state  <= S_ADDR;
                        end else begin
                            r_state  <= S_DONE;
                        end
                    end else begin
                        if (pc_redirect) r_discard <= 1'b1;
                        if (!w_cnt_max)  r_cnt     <= w_cnt_inc;
                    end
                end
                S_DONE: begin
                    if (pc_redirect || !dm_busy) begin
                        r_araddr <= pc_req;
                        r_state  <= S_ADDR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ARID        = ID_W'(FETCH_ID);
    assign ARADDR      = r_araddr;
    assign ARLEN       = 8'd0;
    assign ARSIZE      = 3'b010;
    assign ARBURST     = 2'b01;
    assign ARVALID     = (r_state == S_ADDR);
    assign RREADY      = (r_state == S_DATA);
    assign inst_out    = r_inst;
    assign inst_valid  = (r_state == S_DONE) && !pc_redirect;
    assign fetch_stall = (r_state != S_DONE);
    assign fetch_err   = r_err;

endmodule
